// File: rtl/game_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | game_pkg: shared state encoding and defaults for game flow     |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
package game_pkg;

  localparam int STATE_W        = 3;
  localparam int NUM_LEVELS_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_FAIL      = 3'd4,
    ST_CLEAR     = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lane_scorer.sv
`default_nettype none
// +---------------------------------------------------------------+
// | lane_scorer: weighted hit scoring with saturating combo track  |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
module lane_scorer #(
  parameter int NUM_LANES = 4,
  parameter int LEVEL_W   = 3,
  parameter int SCORE_W   = 12,
  parameter int COMBO_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [NUM_LANES-1:0] hit_i,
  input  logic [NUM_LANES-1:0] miss_i,
  input  logic [LEVEL_W-1:0]   level_i,
  output logic [SCORE_W-1:0]   score_o,
  output logic [COMBO_W-1:0]   combo_o,
  output logic [COMBO_W-1:0]   max_combo_o
);

  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  localparam int PW     = CNT_W + LEVEL_W;
  localparam int SUM_W  = SCORE_W + PW + 1;
  localparam int CSUM_W = COMBO_W + CNT_W + 1;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] max_q, max_d;

  logic [CNT_W-1:0]  hit_cnt;
  logic [PW-1:0]     prod;
  logic [SUM_W-1:0]  score_sum;
  logic [CSUM_W-1:0] combo_sum;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit_cnt = hit_cnt + CNT_W'(hit_i[i]);
    end
    prod      = PW'(hit_cnt) * PW'(level_i);
    score_sum = SUM_W'(score_q) + SUM_W'(prod);
    combo_sum = CSUM_W'(combo_q) + CSUM_W'(hit_cnt);

    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;

    if (clr_i) begin
      score_d = '0;
      combo_d = '0;
      max_d   = '0;
    end else if (en_i) begin
      score_d = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
      // Any miss breaks the streak; same-cycle hits still score but don't count toward combo.
      if (|miss_i) begin
        combo_d = '0;
      end else begin
        combo_d = (combo_sum > CSUM_W'(COMBO_MAX)) ? COMBO_MAX : combo_sum[COMBO_W-1:0];
      end
      if (combo_d > max_q) begin
        max_d = combo_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
    end
  end

  assign score_o     = score_q;
  assign combo_o     = combo_q;
  assign max_combo_o = max_q;

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------+
// | game_flow_ctrl: level select, countdown, play/pause, results  |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS      = NUM_LEVELS_DEF,
  parameter int LEVEL_W         = 3,
  parameter int NUM_LANES       = 4,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int RESULT_TICKS    = 8,
  parameter int SCORE_W         = 12,
  parameter int COMBO_W         = 8,
  localparam int CD_W = ($clog2(COUNTDOWN_TICKS + 1) < 2) ? 2 : $clog2(COUNTDOWN_TICKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 level_valid,
  input  logic [LEVEL_W-1:0]   level_sel,
  input  logic                 pause_req,
  input  logic                 return_req,
  input  logic                 song_end,
  input  logic                 fail,
  input  logic [NUM_LANES-1:0] hit,
  input  logic [NUM_LANES-1:0] miss,
  output logic [STATE_W-1:0]   state,
  output logic [LEVEL_W-1:0]   level,
  output logic                 play_en,
  output logic [CD_W-1:0]      cd_remaining,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic [COMBO_W-1:0]   max_combo
);

  localparam int RES_W = ($clog2(RESULT_TICKS + 1) < 1) ? 1 : $clog2(RESULT_TICKS + 1);
  localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(NUM_LEVELS);

  state_e             state_q;
  logic [LEVEL_W-1:0] level_q;
  logic               play_en_q;
  logic [CD_W-1:0]    cd_q;
  logic [RES_W-1:0]   res_q;

  logic lvl_ok;
  logic score_en;
  logic score_clr;

  assign lvl_ok    = level_valid && (level_sel != '0) && (level_sel <= MAX_LVL);
  assign score_clr = (state_q == ST_IDLE) && lvl_ok;
  // Scoring is suppressed in the cycle the FSM leaves PLAY.
  assign score_en  = (state_q == ST_PLAY) && !fail && !song_end && !pause_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      play_en_q <= 1'b0;
      cd_q      <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lvl_ok) begin
            state_q <= ST_COUNTDOWN;
            level_q <= level_sel;
            cd_q    <= CD_W'(COUNTDOWN_TICKS);
          end
        end
        ST_COUNTDOWN: begin
          if (tick) begin
            if (cd_q == CD_W'(1)) begin
              state_q   <= ST_PLAY;
              play_en_q <= 1'b1;
              cd_q      <= '0;
            end else begin
              cd_q <= cd_q - CD_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (fail) begin
            state_q   <= ST_FAIL;
            play_en_q <= 1'b0;
          end else if (song_end) begin
            state_q   <= ST_CLEAR;
            play_en_q <= 1'b0;
            res_q     <= RES_W'(RESULT_TICKS);
          end else if (pause_req) begin
            state_q   <= ST_PAUSE;
            play_en_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (return_req) begin
            state_q <= ST_IDLE;
          end else if (pause_req) begin
            state_q   <= ST_PLAY;
            play_en_q <= 1'b1;
          end
        end
        ST_FAIL: begin
          if (return_req) begin
            state_q <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (return_req) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
          end else if (tick) begin
            if (res_q <= RES_W'(1)) begin
              state_q <= ST_IDLE;
              res_q   <= '0;
            end else begin
              res_q <= res_q - RES_W'(1);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          play_en_q <= 1'b0;
        end
      endcase
    end
  end

  lane_scorer #(
    .NUM_LANES (NUM_LANES),
    .LEVEL_W   (LEVEL_W),
    .SCORE_W   (SCORE_W),
    .COMBO_W   (COMBO_W)
  ) u_lane_scorer (
    .clk         (clk),
    .rst_n       (rst),
    .en_i        (score_en),
    .clr_i       (score_clr),
    .hit_i       (hit),
    .miss_i      (miss),
    .level_i     (level_q),
    .score_o     (score),
    .combo_o     (combo),
    .max_combo_o (max_combo)
  );

  assign state        = state_q;
  assign level        = level_q;
  assign play_en      = play_en_q;
  assign cd_remaining = cd_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_game_flow_ctrl: directed self-checking bench               |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
module tb_game_flow_ctrl;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        level_valid;
  logic [2:0]  level_sel;
  logic        pause_req;
  logic        return_req;
  logic        song_end;
  logic        fail;
  logic [3:0]  hit;
  logic [3:0]  miss;
  logic [2:0]  state;
  logic [2:0]  level;
  logic        play_en;
  logic [1:0]  cd_remaining;
  logic [11:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;

  int n_vec = 0;
  int n_err = 0;

  game_flow_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .level_valid  (level_valid),
    .level_sel    (level_sel),
    .pause_req    (pause_req),
    .return_req   (return_req),
    .song_end     (song_end),
    .fail         (fail),
    .hit          (hit),
    .miss         (miss),
    .state        (state),
    .level        (level),
    .play_en      (play_en),
    .cd_remaining (cd_remaining),
    .score        (score),
    .combo        (combo),
    .max_combo    (max_combo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    tick = 0; level_valid = 0; level_sel = 0; pause_req = 0;
    return_req = 0; song_end = 0; fail = 0; hit = 0; miss = 0;
  endtask

  task automatic enter_play(input logic [2:0] lvl);
    level_sel = lvl; level_valid = 1; cyc(); clear_in();
    tick = 1; repeat (3) cyc(); tick = 0;
  endtask

  initial begin
    clear_in();
    rst = 0;
    repeat (2) cyc();
    check_val("rst_state", 32'(state), 0);
    check_val("rst_level", 32'(level), 0);
    check_val("rst_play_en", 32'(play_en), 0);
    check_val("rst_cd", 32'(cd_remaining), 0);
    check_val("rst_score", 32'(score), 0);
    check_val("rst_combo", 32'(combo), 0);
    check_val("rst_max", 32'(max_combo), 0);
    rst = 1;
    cyc();

    // Run A: level 3 scoring, fail/song_end together
    enter_play(3'd3);
    check_val("A_play", 32'(state), 2);
    hit = 4'b0101; cyc();
    check_val("A_score1", 32'(score), 6);
    check_val("A_combo1", 32'(combo), 2);
    cyc();
    check_val("A_score2", 32'(score), 12);
    check_val("A_combo2", 32'(combo), 4);
    hit = 4'b0001; miss = 4'b0010; cyc(); clear_in();
    check_val("A_score3", 32'(score), 15);
    check_val("A_combo3", 32'(combo), 0);
    check_val("A_max3", 32'(max_combo), 4);
    fail = 1; song_end = 1; tick = 1; hit = 4'b1111; cyc(); clear_in();
    check_val("A_fail_state", 32'(state), 4);
    check_val("A_fail_play_en", 32'(play_en), 0);
    check_val("A_exit_noscore", 32'(score), 15);
    return_req = 1; cyc(); clear_in();
    check_val("A_ret_state", 32'(state), 0);
    check_val("A_ret_score", 32'(score), 15);
    check_val("A_ret_level", 32'(level), 3);
    check_val("A_ret_max", 32'(max_combo), 4);

    // Run B: out-of-range levels, countdown, pause, clear timeout
    level_sel = 3'd0; level_valid = 1; cyc(); clear_in();
    check_val("B_lvl0", 32'(state), 0);
    level_sel = 3'd5; level_valid = 1; cyc(); clear_in();
    check_val("B_lvl5", 32'(state), 0);
    check_val("B_idle_score", 32'(score), 15);
    level_sel = 3'd2; level_valid = 1; cyc(); clear_in();
    check_val("B_cd_state", 32'(state), 1);
    check_val("B_cd_level", 32'(level), 2);
    check_val("B_cd3", 32'(cd_remaining), 3);
    check_val("B_cd_score_clr", 32'(score), 0);
    check_val("B_cd_max_clr", 32'(max_combo), 0);
    fail = 1; pause_req = 1; song_end = 1; cyc(); clear_in();
    check_val("B_cd_ign_state", 32'(state), 1);
    check_val("B_cd_ign_cd", 32'(cd_remaining), 3);
    tick = 1; cyc();
    check_val("B_cd2", 32'(cd_remaining), 2);
    check_val("B_cd2_state", 32'(state), 1);
    cyc();
    check_val("B_cd1", 32'(cd_remaining), 1);
    cyc(); tick = 0;
    check_val("B_play_state", 32'(state), 2);
    check_val("B_play_cd0", 32'(cd_remaining), 0);
    check_val("B_play_en", 32'(play_en), 1);
    hit = 4'b1000; cyc(); clear_in();
    check_val("B_score", 32'(score), 2);
    pause_req = 1; hit = 4'b1111; cyc(); clear_in();
    check_val("B_pause_state", 32'(state), 3);
    check_val("B_pause_play_en", 32'(play_en), 0);
    check_val("B_pause_exit_noscore", 32'(score), 2);
    hit = 4'b1111; cyc(); clear_in();
    check_val("B_pause_frozen", 32'(score), 2);
    check_val("B_pause_combo", 32'(combo), 1);
    pause_req = 1; cyc(); clear_in();
    check_val("B_resume", 32'(state), 2);
    song_end = 1; cyc(); clear_in();
    check_val("B_clear", 32'(state), 5);
    tick = 1; repeat (7) cyc();
    check_val("B_clear7", 32'(state), 5);
    cyc(); tick = 0;
    check_val("B_clear8", 32'(state), 0);

    // Run C: saturation at level 4, then pause/return priority
    enter_play(3'd4);
    hit = 4'b1111; repeat (255) cyc();
    check_val("C_score255", 32'(score), 4080);
    check_val("C_combo_sat", 32'(combo), 255);
    check_val("C_max_sat", 32'(max_combo), 255);
    cyc();
    check_val("C_score_sat", 32'(score), 4095);
    cyc(); clear_in();
    check_val("C_score_hold", 32'(score), 4095);
    pause_req = 1; cyc(); clear_in();
    check_val("C_pause", 32'(state), 3);
    pause_req = 1; return_req = 1; cyc(); clear_in();
    check_val("C_ret_prio", 32'(state), 0);
    check_val("C_ret_score", 32'(score), 4095);

    // Run D: asynchronous reset mid-PLAY
    enter_play(3'd1);
    hit = 4'b0001; cyc(); clear_in();
    check_val("D_score", 32'(score), 1);
    #2 rst = 0;
    #1;
    check_val("D_async_state", 32'(state), 0);
    check_val("D_async_score", 32'(score), 0);
    check_val("D_async_level", 32'(level), 0);
    check_val("D_async_play_en", 32'(play_en), 0);
    #1 rst = 1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller for the rhythm game: replaces the fixed start/difficulty/failure state logic in the top level with one registered FSM supporting NUM_LEVELS difficulties, a pre-play countdown, pause/resume, a clear (win) result screen with auto-return, and per-lane scoring with combo tracking. It sits between the menu/judge/player blocks and the renderers, composite mux and music. All of these consume its registered state and score outputs.

## Interface
Parameters:
- NUM_LEVELS, 4: selectable difficulties, coded 1..NUM_LEVELS; 0 means none.
- LEVEL_W, 3: level code width; must satisfy 2^LEVEL_W > NUM_LEVELS.
- NUM_LANES, 4: hit/miss lanes.
- COUNTDOWN_TICKS, 3: ticks spent in COUNTDOWN.
- RESULT_TICKS, 8: ticks before CLEAR auto-returns.
- SCORE_W, 12: score width.
- COMBO_W, 8: combo and max-combo width.

Ports:
- clk  in  1: system clock, single domain.
- rst  in  1: asynchronous, active-low reset.
- tick  in  1: one-cycle timebase enable, synchronous to clk.
- level_valid  in  1: pulse; latch level_sel.
- level_sel  in  LEVEL_W: requested difficulty.
- pause_req  in  1: pulse; toggles pause.
- return_req  in  1: pulse; leave PAUSE/FAIL/CLEAR.
- song_end  in  1: pulse; script finished.
- fail  in  1: pulse; player out of life.
- hit  in  NUM_LANES: per-lane hit pulses.
- miss  in  NUM_LANES: per-lane miss pulses.
- state  out  3: IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, FAIL=4, CLEAR=5.
- level  out  LEVEL_W: active difficulty.
- play_en  out  1: high only in PLAY.
- cd_remaining  out  2+: ticks left in COUNTDOWN; width is clog2(COUNTDOWN_TICKS+1).
- score  out  SCORE_W: accumulated score.
- combo  out  COMBO_W: current combo.
- max_combo  out  COMBO_W: best combo this run.

## Operation
- IDLE→COUNTDOWN: level_valid with 1≤level_sel≤NUM_LEVELS. The block latches level and loads cd_remaining=COUNTDOWN_TICKS. It also clears score, combo and max_combo. Out-of-range level_sel is ignored.
- COUNTDOWN: each tick decrements cd_remaining. A tick seen while cd_remaining==1 moves the FSM to PLAY with cd_remaining=0. pause_req, fail and song_end are ignored here.
- PLAY transitions, in priority order:
  - fail→FAIL.
  - song_end→CLEAR; load result counter with RESULT_TICKS.
  - pause_req→PAUSE.
- PAUSE: pause_req→PLAY. return_req→IDLE, with return_req taking priority. Score, combo and other inputs are frozen.
- FAIL: return_req→IDLE. Score and max_combo are held for display.
- CLEAR: return_req→IDLE, or the RESULT_TICKS-th tick→IDLE.
- Scoring applies only in PLAY, and only in a cycle where the FSM stays in PLAY:
  - score += popcount(hit)×level, saturating at 2^SCORE_W−1.
  - combo: if any miss bit is set, combo=0 and the same-cycle hits are discarded for combo but still scored. Otherwise combo += popcount(hit), saturating.
  - max_combo = max(max_combo, new combo).
- Hits and misses arriving in the cycle of a PLAY exit are not scored.
- Entering IDLE keeps score and level. They clear only on the next COUNTDOWN entry.

## Timing
- All outputs are registered. A state change is visible the cycle after the qualifying input pulse.
- Score and combo update the cycle after the hit/miss pulse.
- Reset values:
  - state=IDLE, level=0, play_en=0, cd_remaining=0.
  - score=0, combo=0, max_combo=0, result counter=0.
- tick and an event in the same cycle: the event transition wins, and the tick is consumed without effect.
- Reset assertion mid-PLAY forces all reset values immediately, asynchronously. Reset deassertion is synchronised externally.
- COUNTDOWN lasts exactly COUNTDOWN_TICKS ticks. The default CLEAR lasts exactly RESULT_TICKS ticks.

## Structure
- A shared package game_pkg holds:
  - the state encoding constants (IDLE..CLEAR);
  - the state width;
  - the NUM_LEVELS default.
- Renderers, music and the composite mux import game_pkg.
- One sub-module, lane_scorer: popcount, weighted add, saturation and combo/max_combo logic. It takes an enable input driven from the FSM.

## Test plan
- Reset, then level_valid with level_sel=2, then 3 ticks → state reads 1 for 3 ticks, then 2. level=2 and cd_remaining goes 3,2,1,0.
- level_sel=0, then 5 with NUM_LEVELS=4 → state stays 0.
- In PLAY at level 3, hit=4'b0101 twice, then miss=4'b0010 with hit=4'b0001 → score=15 and combo ends at 0. max_combo=4.
- In PLAY, fail and song_end in the same cycle → state=4. Then return_req → state=0 with score retained.
- pause_req, hits during PAUSE, then pause_req → score unchanged. State goes 3, then 2.
- song_end → state=5; after 8 ticks → state=0. With score near max, hits → score saturates at 4095.
